// File: rtl/i2s_receiver_if.sv
`default_nettype none
// ============================================================================
// Module   : i2s_receiver_if
// Brief    : I2S serial lines from the codec plus the parallel sample outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface i2s_receiver_if #(
    parameter int SAMPLE_W = 24
);
    logic                LRCLK;
    logic                SCLK;
    logic                SDATA;
    logic [SAMPLE_W-1:0] left_sample;
    logic [SAMPLE_W-1:0] right_sample;
    logic                sample_valid;
    logic                frame_err;

    // The codec is the bus master: it drives the serial lines.
    modport master (
        output LRCLK, SCLK, SDATA,
        input  left_sample, right_sample, sample_valid, frame_err
    );

    modport slave (
        input  LRCLK, SCLK, SDATA,
        output left_sample, right_sample, sample_valid, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/i2s_receiver.sv
`default_nettype none
// ============================================================================
// Module   : i2s_receiver
// Brief    : I2S ADC stream to parallel left/right samples in the clk domain.
//            Optional slot-length checking under I2S_RX_FRAME_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_receiver #(
    parameter int SAMPLE_W = 24,
    parameter int SLOT_W   = 32
) (
    input  logic          clk,
    input  logic          reset,
    i2s_receiver_if.slave bus
);

    localparam int                 c_CNT_W = $clog2(SLOT_W + 1);
    localparam logic [c_CNT_W-1:0] c_BITS  = c_CNT_W'(SAMPLE_W);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(SAMPLE_W - 1);

    localparam logic [1:0] c_ST_SYNC  = 2'd0;
    localparam logic [1:0] c_ST_LEFT  = 2'd1;
    localparam logic [1:0] c_ST_RIGHT = 2'd2;

    logic r_lr_s1, r_lr_s2;
    logic r_sclk_s1, r_sclk_s2, r_sclk_s3;
    logic r_sd_s1, r_sd_s2;

    logic                r_lr_prev;
    logic [c_CNT_W-1:0]  r_bit_cnt;
    logic [SAMPLE_W-1:0] r_shreg;
    logic [SAMPLE_W-1:0] r_left_stage;
    logic                r_left_ok;
    logic                r_pair_pend;
    logic [1:0]          r_state;
    logic [SAMPLE_W-1:0] r_left_sample;
    logic [SAMPLE_W-1:0] r_right_sample;
    logic                r_sample_valid;

    logic                w_rise;
    logic                w_bound;
    logic                w_shift;
    logic                w_word_done;
    logic [SAMPLE_W-1:0] w_shreg_nxt;
    logic [1:0]          w_state_nxt;
    logic                w_left_ok_nxt;
    logic                w_stage_ld;
    logic                w_pair_ld;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lr_s1   <= 1'b0;
            r_lr_s2   <= 1'b0;
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_s3 <= 1'b0;
            r_sd_s1   <= 1'b0;
            r_sd_s2   <= 1'b0;
        end else begin
            r_lr_s1   <= bus.LRCLK;
            r_lr_s2   <= r_lr_s1;
            r_sclk_s1 <= bus.SCLK;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_s3 <= r_sclk_s2;
            r_sd_s1   <= bus.SDATA;
            r_sd_s2   <= r_sd_s1;
        end
    end

    // The boundary rise carries the previous slot's LSB, so it never shifts.
    assign w_rise      = r_sclk_s2 & ~r_sclk_s3;
    assign w_bound     = w_rise & (r_lr_s2 != r_lr_prev);
    assign w_shift     = w_rise & ~w_bound & (r_bit_cnt < c_BITS);
    assign w_word_done = w_shift & (r_bit_cnt == c_LAST);
    assign w_shreg_nxt = {r_shreg[SAMPLE_W-2:0], r_sd_s2};

    always_comb begin
        w_state_nxt   = r_state;
        w_left_ok_nxt = r_left_ok;
        w_stage_ld    = 1'b0;
        w_pair_ld     = 1'b0;
        if (w_bound) begin
            if (r_lr_s2) begin
                if (r_state != c_ST_SYNC) begin
                    w_state_nxt = c_ST_RIGHT;
                    // A short left word or an out-of-order boundary voids the pair.
                    if ((r_state != c_ST_LEFT) || (r_bit_cnt != c_BITS))
                        w_left_ok_nxt = 1'b0;
                end
            end else begin
                w_state_nxt   = c_ST_LEFT;
                w_left_ok_nxt = 1'b0;
            end
        end else if (w_word_done) begin
            case (r_state)
                c_ST_LEFT: begin
                    w_stage_ld    = 1'b1;
                    w_left_ok_nxt = 1'b1;
                end
                c_ST_RIGHT: begin
                    w_pair_ld     = r_left_ok;
                    w_left_ok_nxt = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= c_ST_SYNC;
            r_left_ok      <= 1'b0;
            r_lr_prev      <= 1'b0;
            r_bit_cnt      <= '0;
            r_shreg        <= '0;
            r_left_stage   <= '0;
            r_pair_pend    <= 1'b0;
            r_left_sample  <= '0;
            r_right_sample <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_left_ok   <= w_left_ok_nxt;
            r_pair_pend <= w_pair_ld;
            if (w_rise)
                r_lr_prev <= r_lr_s2;
            if (w_bound)
                r_bit_cnt <= '0;
            else if (w_shift)
                r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_shift)
                r_shreg <= w_shreg_nxt;
            if (w_stage_ld)
                r_left_stage <= w_shreg_nxt;
            r_sample_valid <= r_pair_pend;
            if (r_pair_pend) begin
                r_left_sample  <= r_left_stage;
                r_right_sample <= r_shreg;
            end
        end
    end

    assign bus.left_sample  = r_left_sample;
    assign bus.right_sample = r_right_sample;
    assign bus.sample_valid = r_sample_valid;

`ifdef I2S_RX_FRAME_CHECK_EN
    localparam int                   c_SLOT_CW  = $clog2(SLOT_W + 2);
    localparam logic [c_SLOT_CW-1:0] c_SLOT_LEN = c_SLOT_CW'(SLOT_W);
    localparam logic [c_SLOT_CW-1:0] c_SLOT_MAX = '1;

    logic [c_SLOT_CW-1:0] r_slot_cnt;
    logic                 r_frame_err;

    // The boundary rise opens the new slot with a count of one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot_cnt  <= '0;
            r_frame_err <= 1'b0;
        end else if (w_rise) begin
            if (w_bound) begin
                if ((r_state != c_ST_SYNC) && (r_slot_cnt != c_SLOT_LEN))
                    r_frame_err <= 1'b1;
                r_slot_cnt <= c_SLOT_CW'(1);
            end else if (r_slot_cnt != c_SLOT_MAX) begin
                r_slot_cnt <= r_slot_cnt + 1'b1;
            end
        end
    end

    assign bus.frame_err = r_frame_err;
`else
    assign bus.frame_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2s_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_receiver
// Brief    : Directed bench for i2s_receiver, codec modelled at SCLK = clk/16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_receiver;

    localparam int SW   = 24;
    localparam int SLOT = 32;
    localparam int HALF = 8;
`ifdef I2S_RX_FRAME_CHECK_EN
    localparam logic FC = 1'b1;
`else
    localparam logic FC = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #10 clk = ~clk;

    i2s_receiver_if #(.SAMPLE_W(SW)) bus ();

    i2s_receiver #(.SAMPLE_W(SW), .SLOT_W(SLOT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [SW-1:0] l;
        logic [SW-1:0] r;
        logic [SW-1:0] exp_l;
        logic [SW-1:0] exp_r;
    } vec_t;
    vec_t vecs [5];

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    int run_len = 0;
    int wide = 0;
    int unstable = 0;
    logic [SW-1:0] mon_l = '0;
    logic [SW-1:0] mon_r = '0;

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            if (bus.sample_valid === 1'b1) begin
                pulses++;
                run_len++;
                if (run_len > 1) wide++;
            end else begin
                run_len = 0;
                if ((bus.left_sample !== mon_l) || (bus.right_sample !== mon_r))
                    unstable++;
            end
        end else begin
            run_len = 0;
        end
        mon_l = bus.left_sample;
        mon_r = bus.right_sample;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sclk_bit(input logic lr, input logic d);
        bus.LRCLK = lr;
        bus.SDATA = d;
        repeat (HALF) @(negedge clk);
        bus.SCLK = 1'b1;
        repeat (HALF) @(negedge clk);
        bus.SCLK = 1'b0;
    endtask

    // I2S: MSB on the second SCLK of the slot, zero padding after the LSB.
    function automatic logic slot_bit(input logic [SW-1:0] w, input int k);
        if (k >= 1 && k <= SW) return w[SW-k];
        return 1'b0;
    endfunction

    task automatic send_slot(input logic lr, input logic [SW-1:0] w, input int nbits);
        for (int k = 0; k < nbits; k++) sclk_bit(lr, slot_bit(w, k));
    endtask

    task automatic send_frame(input logic [SW-1:0] l, input logic [SW-1:0] r);
        send_slot(1'b0, l, SLOT);
        send_slot(1'b1, r, SLOT);
    endtask

    task automatic chk_pair(input string name, input int p0, input int npulse,
                            input logic [SW-1:0] el, input logic [SW-1:0] er);
        chk({name, "_pulses"}, 32'(pulses - p0), 32'(npulse));
        chk({name, "_left"},   32'(bus.left_sample),  32'(el));
        chk({name, "_right"},  32'(bus.right_sample), 32'(er));
    endtask

    initial begin
        int p0;
        vecs[0] = '{24'h123456, 24'hABCDEF, 24'h123456, 24'hABCDEF};
        vecs[1] = '{24'h800000, 24'hFFFFFF, 24'h800000, 24'hFFFFFF};
        vecs[2] = '{24'h000000, 24'h000001, 24'h000000, 24'h000001};
        vecs[3] = '{24'h7FFFFF, 24'h800001, 24'h7FFFFF, 24'h800001};
        vecs[4] = '{24'hA5A5A5, 24'h5A5A5A, 24'hA5A5A5, 24'h5A5A5A};

        bus.LRCLK = 1'b1;
        bus.SCLK  = 1'b0;
        bus.SDATA = 1'b0;
        reset     = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_left",  32'(bus.left_sample),  32'h0);
        chk("rst_right", 32'(bus.right_sample), 32'h0);
        chk("rst_valid", 32'(bus.sample_valid), 32'h0);
        chk("rst_err",   32'(bus.frame_err),    32'h0);
        reset = 1'b0;

        // Stream picked up mid-right-slot: nothing until a full pair follows 1->0.
        p0 = pulses;
        send_slot(1'b1, 24'h55AA55, 12);
        chk("midright_none", 32'(pulses - p0), 32'h0);
        send_frame(24'h0F0F0F, 24'hF0F0F0);
        chk_pair("midright_first", p0, 1, 24'h0F0F0F, 24'hF0F0F0);

        for (int i = 0; i < 5; i++) begin
            p0 = pulses;
            send_frame(vecs[i].l, vecs[i].r);
            chk_pair($sformatf("vec%0d", i), p0, 1, vecs[i].exp_l, vecs[i].exp_r);
            chk($sformatf("vec%0d_err", i), 32'(bus.frame_err), 32'h0);
        end

        // Latency: edge 1 is the first clk edge seeing SCLK high for right bit SW.
        p0 = pulses;
        send_slot(1'b0, 24'h13579B, SLOT);
        for (int k = 0; k < SW; k++) sclk_bit(1'b1, slot_bit(24'h2468AC, k));
        bus.LRCLK = 1'b1;
        bus.SDATA = slot_bit(24'h2468AC, SW);
        repeat (HALF) @(negedge clk);
        bus.SCLK = 1'b1;
        repeat (3) @(negedge clk);
        chk("lat_edge3", 32'(bus.sample_valid), 32'h0);
        @(negedge clk);
        chk("lat_edge4", 32'(bus.sample_valid), 32'h1);
        @(negedge clk);
        chk("lat_edge5", 32'(bus.sample_valid), 32'h0);
        repeat (HALF - 5) @(negedge clk);
        bus.SCLK = 1'b0;
        for (int k = SW + 1; k < SLOT; k++) sclk_bit(1'b1, slot_bit(24'h2468AC, k));
        chk_pair("lat", p0, 1, 24'h13579B, 24'h2468AC);

        // SCLK stalled low for 10 us.
        p0 = pulses;
        repeat (500) @(negedge clk);
        chk_pair("stall", p0, 0, 24'h13579B, 24'h2468AC);

        p0 = pulses;
        for (int i = 0; i < 20; i++) send_frame(24'(i * 24'h010203), 24'(24'hFFFFFF - i));
        chk_pair("run20", p0, 20, 24'(19 * 24'h010203), 24'(24'hFFFFFF - 19));
        chk("run20_err", 32'(bus.frame_err), 32'h0);

        // Reset during bit 12 of a right word.
        send_slot(1'b0, 24'h777777, SLOT);
        send_slot(1'b1, 24'h888888, 13);
        #3 reset = 1'b1;
        #1;
        chk("midrst_left",  32'(bus.left_sample),  32'h0);
        chk("midrst_right", 32'(bus.right_sample), 32'h0);
        chk("midrst_valid", 32'(bus.sample_valid), 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        p0 = pulses;
        for (int k = 13; k < SLOT; k++) sclk_bit(1'b1, slot_bit(24'h888888, k));
        chk("midrst_none", 32'(pulses - p0), 32'h0);
        send_frame(24'h246801, 24'h135790);
        chk_pair("midrst_first", p0, 1, 24'h246801, 24'h135790);
        chk("midrst_err", 32'(bus.frame_err), 32'h0);

        // Left slot cut to 20 SCLKs: pair dropped, previous values held.
        p0 = pulses;
        send_slot(1'b0, 24'h111111, 20);
        send_slot(1'b1, 24'h222222, SLOT);
        chk_pair("short", p0, 0, 24'h246801, 24'h135790);
        chk("short_err", 32'(bus.frame_err), 32'(FC));
        p0 = pulses;
        send_frame(24'h333333, 24'h444444);
        chk_pair("after_short", p0, 1, 24'h333333, 24'h444444);
        chk("after_short_err", 32'(bus.frame_err), 32'(FC));

        chk("pulse_width", 32'(wide), 32'h0);
        chk("outputs_stable", 32'(unstable), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
